// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 stream receiver: FSM states, register
// offsets and STATUS field positions.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } ws_state_e;

    localparam logic [31:0] WORD_BASE = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0020;

    localparam int ST_VALID     = 0;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 4;
    localparam int ST_OVERFLOW  = 16;
    localparam int ST_GLITCH    = 17;
    localparam int ST_LONG      = 18;
    localparam int ST_PARTIAL   = 19;

    localparam int BITS_PER_WORD = 24;
    localparam int BCNT_W        = $clog2(BITS_PER_WORD);

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Pin synchroniser, pulse-width measurement FSM and latch-gap detection.
// Emits single-cycle strobes for decoded bits, frame end and pulse errors.
module ws2812_bit_decoder
    import ws2812_pkg::*;
#(
    parameter int THRESH    = 60,
    parameter int MIN_HIGH  = 20,
    parameter int MAX_HIGH  = 110,
    parameter int RESET_LOW = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_bit_valid,
    output logic o_bit_val,
    output logic o_frame_end,
    output logic o_err_glitch,
    output logic o_err_long
);

    localparam int CNT_W = $clog2(RESET_LOW + 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] LOW_C    = CNT_W'(RESET_LOW);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic      r_din_p0, r_din_p1, r_din_p2;
    logic      w_rise, w_fall;
    ws_state_e r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
    logic [CNT_W-1:0] r_lcnt, w_lcnt_nxt;
    logic [CNT_W-1:0] w_lcnt_inc;

    // Stage p0/p1: metastability guard; p2: one-cycle delay for edge detect
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_din_p0 <= 1'b0;
            r_din_p1 <= 1'b0;
            r_din_p2 <= 1'b0;
        end else begin
            r_din_p0 <= i_din;
            r_din_p1 <= r_din_p0;
            r_din_p2 <= r_din_p1;
        end
    end

    assign w_rise     = r_din_p1 & ~r_din_p2;
    assign w_fall     = ~r_din_p1 & r_din_p2;
    assign w_lcnt_inc = sat_inc(r_lcnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SYNC;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_lcnt_nxt   = r_lcnt;
        o_bit_valid  = 1'b0;
        o_bit_val    = 1'b0;
        o_frame_end  = 1'b0;
        o_err_glitch = 1'b0;
        o_err_long   = 1'b0;
        case (r_state)
            SYNC: begin
                if (r_din_p1) begin
                    w_lcnt_nxt = '0;
                end else if (w_lcnt_inc >= LOW_C) begin
                    w_lcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_hcnt_nxt  = CNT_W'(1);
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_lcnt_nxt = '0;
                    if (r_hcnt < MIN_C) begin
                        o_err_glitch = 1'b1;
                        w_state_nxt  = SYNC;
                    end else if (r_hcnt > MAX_C) begin
                        o_err_long  = 1'b1;
                        w_state_nxt = SYNC;
                    end else begin
                        o_bit_valid = 1'b1;
                        o_bit_val   = (r_hcnt >= THRESH_C);
                        w_state_nxt = LOW;
                    end
                end else if (r_hcnt > MAX_C) begin
                    // Stuck-high line: abandon the frame and wait for a latch gap
                    o_err_long  = 1'b1;
                    w_lcnt_nxt  = '0;
                    w_state_nxt = SYNC;
                end else begin
                    w_hcnt_nxt = sat_inc(r_hcnt);
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_hcnt_nxt  = CNT_W'(1);
                    w_state_nxt = HIGH;
                end else if (r_lcnt >= LOW_C) begin
                    o_frame_end = 1'b1;
                    w_lcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

endmodule

// File: rtl/ws2812_rx_apb.sv
// WS2812 stream receiver top: packs decoded bits into 24-bit words, double
// buffers a frame and exposes it plus sticky status over APB3.
module ws2812_rx_apb
    import ws2812_pkg::*;
#(
    parameter int CLK_PER_BIT = 125,
    parameter int THRESH      = 60,
    parameter int MIN_HIGH    = 20,
    parameter int MAX_HIGH    = 110,
    parameter int RESET_LOW   = 2500,
    parameter int NUM_WORDS   = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        DIN
);

    localparam int WIDX_W = $clog2(NUM_WORDS + 1);
    localparam logic [WIDX_W-1:0] WIDX_LIM = WIDX_W'(NUM_WORDS);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BITS_PER_WORD - 1);
    localparam logic CPB_OK = (CLK_PER_BIT > 0);

    logic w_bit_valid, w_bit_val, w_frame_end, w_err_glitch, w_err_long;

    logic [BITS_PER_WORD-1:0] r_shift;
    logic [BITS_PER_WORD-1:0] w_word;
    logic [BCNT_W-1:0]        r_bcnt;
    logic [WIDX_W-1:0]        r_widx;
    logic [WIDX_W-1:0]        r_count;
    logic [BITS_PER_WORD-1:0] r_cap [NUM_WORDS];
    logic [BITS_PER_WORD-1:0] r_rd  [NUM_WORDS];
    logic r_valid, r_ovf, r_glitch, r_long, r_partial;

    logic w_word_done, w_has_room, w_commit, w_set_ovf, w_set_partial;
    logic w_w1c, w_is_status;
    logic w_clr_valid, w_clr_ovf, w_clr_glitch, w_clr_long, w_clr_partial;
    logic [31:0] w_status;
    logic [BITS_PER_WORD-1:0] w_rd_word;
    logic w_unused_ok;

    ws2812_bit_decoder #(
        .THRESH    (THRESH),
        .MIN_HIGH  (MIN_HIGH),
        .MAX_HIGH  (MAX_HIGH),
        .RESET_LOW (RESET_LOW)
    ) u_dec (
        .i_clk        (PCLK),
        .i_rst        (PRESET),
        .i_din        (DIN),
        .o_bit_valid  (w_bit_valid),
        .o_bit_val    (w_bit_val),
        .o_frame_end  (w_frame_end),
        .o_err_glitch (w_err_glitch),
        .o_err_long   (w_err_long)
    );

    always_comb begin
        w_word         = r_shift;
        w_word[r_bcnt] = w_bit_val;
    end

    assign w_word_done   = w_bit_valid & (r_bcnt == LAST_BIT);
    assign w_has_room    = (r_widx < WIDX_LIM);
    assign w_set_ovf     = w_word_done & ~w_has_room;
    assign w_set_partial = w_frame_end & (r_bcnt != '0);
    assign w_commit      = w_frame_end & (r_widx != '0);

    assign w_is_status   = (PADDR[5:2] == STATUS_OFF[5:2]);
    assign w_w1c         = PSEL & PENABLE & PWRITE & w_is_status;
    assign w_clr_valid   = w_w1c & PWDATA[ST_VALID];
    assign w_clr_ovf     = w_w1c & PWDATA[ST_OVERFLOW];
    assign w_clr_glitch  = w_w1c & PWDATA[ST_GLITCH];
    assign w_clr_long    = w_w1c & PWDATA[ST_LONG];
    assign w_clr_partial = w_w1c & PWDATA[ST_PARTIAL];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_shift <= '0;
            r_bcnt  <= '0;
            r_widx  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_cap[i] <= '0;
                r_rd[i]  <= '0;
            end
        end else begin
            if (w_bit_valid) begin
                r_shift <= w_word;
                r_bcnt  <= w_word_done ? '0 : r_bcnt + 1'b1;
                if (w_word_done && w_has_room) begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (r_widx == WIDX_W'(i)) r_cap[i] <= w_word;
                    end
                    r_widx <= r_widx + 1'b1;
                end
            end
            // Any aborted pulse or frame boundary drops the partially built word
            if (w_err_glitch || w_err_long || w_frame_end) r_bcnt <= '0;
            if (w_frame_end) begin
                r_widx <= '0;
                if (w_commit) begin
                    r_rd    <= r_cap;
                    r_count <= r_widx;
                end
            end
        end
    end

    // Sticky flags: a same-cycle set beats the W1C clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_glitch  <= 1'b0;
            r_long    <= 1'b0;
            r_partial <= 1'b0;
        end else begin
            r_valid   <= w_commit      | (r_valid   & ~w_clr_valid);
            r_ovf     <= w_set_ovf     | (r_ovf     & ~w_clr_ovf);
            r_glitch  <= w_err_glitch  | (r_glitch  & ~w_clr_glitch);
            r_long    <= w_err_long    | (r_long    & ~w_clr_long);
            r_partial <= w_set_partial | (r_partial & ~w_clr_partial);
        end
    end

    always_comb begin
        w_status = '0;
        w_status[ST_VALID]                    = r_valid;
        w_status[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(r_count);
        w_status[ST_OVERFLOW]                 = r_ovf;
        w_status[ST_GLITCH]                   = r_glitch;
        w_status[ST_LONG]                     = r_long;
        w_status[ST_PARTIAL]                  = r_partial;
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (PADDR[4:2] == 3'(i)) w_rd_word = r_rd[i];
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            if (PADDR[5] == WORD_BASE[5]) begin
                PRDATA = {8'h00, w_rd_word};
            end else if (w_is_status) begin
                PRDATA = w_status;
            end
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign w_unused_ok = ^{PADDR[31:6], PADDR[1:0], PWDATA[31:20], PWDATA[15:1], CPB_OK};

endmodule

// File: tb/tb_ws2812_rx_apb.sv
// Directed bench for ws2812_rx_apb: drives WS2812 waveforms on DIN and checks
// frame buffer and STATUS contents over APB.
module tb_ws2812_rx_apb;

    localparam int HI1 = 81;
    localparam int LO1 = 44;
    localparam int HI0 = 41;
    localparam int LO0 = 84;
    localparam int RL  = 2500;
    localparam logic [31:0] A_STATUS = 32'h20;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        DIN = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    ws2812_rx_apb dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .DIN     (DIN)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic send_bit(input logic b);
        DIN = 1'b1;
        tick(b ? HI1 : HI0);
        DIN = 1'b0;
        tick(b ? LO1 : LO0);
    endtask

    task automatic send_word(input logic [23:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        PRESET = 1'b1;
        tick(4);
        PRESET = 1'b0;
        PADDR = A_STATUS;
        #1;
        n_checks++;
        if (PRDATA !== 32'h0) begin
            n_fail++; $display("FAIL idle_prdata: got %h expected %h", PRDATA, 32'h0);
        end
        n_checks++;
        if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
            n_fail++; $display("FAIL ready_slverr: got %b%b expected 10", PREADY, PSLVERR);
        end
        @(negedge PCLK);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got %h expected %h", rd, 32'h0);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_word0: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        tick(RL + 20);
        send_word(24'hA5C3F0, 24);
        tick(2600);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h101) begin
            n_fail++; $display("FAIL frame_status: got %h expected %h", rd, 32'h101);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h00A5C3F0) begin
            n_fail++; $display("FAIL frame_word0: got %h expected %h", rd, 32'h00A5C3F0);
        end
        apb_read(32'h4, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL frame_word1: got %h expected %h", rd, 32'h0);
        end
        apb_read(32'h24, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read: got %h expected %h", rd, 32'h0);
        end
        apb_write(32'h0, 32'hFFFF_FFFF);
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h00A5C3F0) begin
            n_fail++; $display("FAIL word_write_ignored: got %h expected %h", rd, 32'h00A5C3F0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        for (int k = 1; k <= 9; k++) send_word(24'(k), 24);
        tick(2600);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0001_0801) begin
            n_fail++; $display("FAIL ovf_status: got %h expected %h", rd, 32'h0001_0801);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL ovf_word0: got %h expected %h", rd, 32'h1);
        end
        apb_read(32'h1C, rd);
        n_checks++;
        if (rd !== 32'h8) begin
            n_fail++; $display("FAIL ovf_word7: got %h expected %h", rd, 32'h8);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        logic [23:0] w;
        apb_write(A_STATUS, 32'h0001_0001);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h800) begin
            n_fail++; $display("FAIL w1c_status: got %h expected %h", rd, 32'h800);
        end
        // Align the W1C access edge with the commit edge of the next frame
        w = 24'h0000AB;
        send_word(w, 24);
        tick(RL + 2 - (w[23] ? LO1 : LO0));
        apb_write(A_STATUS, 32'h0001_0001);
        tick(10);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h101) begin
            n_fail++; $display("FAIL commit_beats_w1c: got %h expected %h", rd, 32'h101);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'hAB) begin
            n_fail++; $display("FAIL commit_word0: got %h expected %h", rd, 32'hAB);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        apb_write(A_STATUS, 32'h000F_0001);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h100) begin
            n_fail++; $display("FAIL glitch_pre_status: got %h expected %h", rd, 32'h100);
        end
        send_word(24'h00000D, 5);
        DIN = 1'b1;
        tick(10);
        DIN = 1'b0;
        tick(100);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0002_0100) begin
            n_fail++; $display("FAIL glitch_flag: got %h expected %h", rd, 32'h0002_0100);
        end
        // Still hunting for a latch gap: this word must be ignored
        send_word(24'h777777, 24);
        tick(2600);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0002_0100) begin
            n_fail++; $display("FAIL glitch_sync_ignore: got %h expected %h", rd, 32'h0002_0100);
        end
        send_word(24'h3C3C3C, 24);
        tick(2600);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0002_0101) begin
            n_fail++; $display("FAIL glitch_recover_status: got %h expected %h", rd, 32'h0002_0101);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h003C3C3C) begin
            n_fail++; $display("FAIL glitch_recover_word0: got %h expected %h", rd, 32'h003C3C3C);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd;
        apb_write(A_STATUS, 32'h000F_0001);
        send_word(24'h123456, 24);
        send_word(24'h00002A, 6);
        tick(2600);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0008_0101) begin
            n_fail++; $display("FAIL partial_status: got %h expected %h", rd, 32'h0008_0101);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h00123456) begin
            n_fail++; $display("FAIL partial_word0: got %h expected %h", rd, 32'h00123456);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        apb_write(A_STATUS, 32'h000F_0001);
        send_word(24'h000ABC, 12);
        PRESET = 1'b1;
        tick(2);
        PRESET = 1'b0;
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL midreset_status: got %h expected %h", rd, 32'h0);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL midreset_word0: got %h expected %h", rd, 32'h0);
        end
        tick(2600);
        send_word(24'h5A5A5A, 24);
        tick(2600);
        apb_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h101) begin
            n_fail++; $display("FAIL fresh_status: got %h expected %h", rd, 32'h101);
        end
        apb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h005A5A5A) begin
            n_fail++; $display("FAIL fresh_word0: got %h expected %h", rd, 32'h005A5A5A);
        end
        apb_read(32'h4, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL fresh_word1: got %h expected %h", rd, 32'h0);
        end
    endtask

    initial begin
        @(negedge PCLK);
        test_reset();
        test_single_frame();
        test_overflow();
        test_w1c();
        test_glitch();
        test_partial();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
